// File: rtl/input_stabilizer.sv
// Two-flop synchronizer plus debounce filter for the external input word.
// A new value reaches input_data only after it has held for STABLE_CYCLES+1 synchronized samples.
module input_stabilizer #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] input_data,
    output logic             data_valid,
    output logic             changed
);

    typedef enum logic [1:0] {
        INIT,
        STABLE,
        SETTLING
    } state_t;

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] candidate_q, candidate_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= INIT;
            sync1_q     <= '0;
            sync2_q     <= '0;
            candidate_q <= '0;
            data_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= raw_in;
            sync2_q     <= sync1_q;
            candidate_q <= candidate_d;
            data_q      <= data_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
        end
    end

    // INIT and SETTLING share the count-and-commit path; only the commit side effects differ.
    always_comb begin
        state_d     = state_q;
        candidate_d = candidate_q;
        data_d      = data_q;
        count_d     = count_q;
        valid_d     = valid_q;
        changed_d   = 1'b0;
        case (state_q)
            INIT, SETTLING: begin
                if (sync2_q != candidate_q) begin
                    candidate_d = sync2_q;
                    count_d     = 8'd1;
                end else if (count_q == STABLE_CNT) begin
                    state_d = STABLE;
                    if (candidate_q != data_q) begin
                        data_d    = candidate_q;
                        changed_d = (state_q == SETTLING);
                    end
                    if (state_q == INIT) begin
                        valid_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            STABLE: begin
                if (sync2_q != data_q) begin
                    candidate_d = sync2_q;
                    count_d     = 8'd1;
                    state_d     = SETTLING;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign input_data = data_q;
    assign data_valid = valid_q;
    assign changed    = changed_q;

endmodule

// File: doc/input_stabilizer.md
# input_stabilizer

Synchronizes and debounces the raw 16-bit external input word and delivers a glitch-free `input_data` bus, plus a change strobe, to the reset-control stage directly downstream. No input transition reaches that stage until the value has held for a programmable number of cycles. This means a transient on the input word can never trigger a processor reset. The block also contains the only clock-domain crossing on the input path.

## Interface
- `WIDTH`, 16, width of the input word.
- `STABLE_CYCLES`, 4, consecutive synchronized cycles a new value must hold before commit (legal range 1..255).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `raw_in`  in  WIDTH  asynchronous external input word.
- `input_data`  out  WIDTH  debounced word; feeds the reset-control `input_data` port.
- `data_valid`  out  1  high once the first value has been committed after reset.
- `changed`  out  1  one-cycle pulse in the cycle after `input_data` takes a new, different value.

## Operation
- Synchronizer: `sync1 <= raw_in`, `sync2 <= sync1` on every edge. Only `sync2` is used downstream.
- Holding registers: `candidate` (WIDTH bits) and `count` (8 bits, saturating at `STABLE_CYCLES`).
- States:
  - INIT: entered on reset with `candidate`=0 and `count`=0.
  - STABLE.
  - SETTLING.
- INIT and SETTLING behave identically on each edge:
  - If `sync2 != candidate`: `candidate <= sync2`, `count <= 1`.
  - Else if `count == STABLE_CYCLES`: commit.
  - Else: `count <= count+1`.
- Commit:
  - `state <= STABLE`.
  - If `candidate != input_data`: `input_data <= candidate`. `changed <= 1` only if leaving SETTLING.
  - If leaving INIT: `data_valid <= 1`, and no `changed` pulse.
  - If `candidate == input_data` (the glitch returned to the old value): no update and no pulse.
- STABLE: if `sync2 != input_data`, then `candidate <= sync2`, `count <= 1`, and `state <= SETTLING`. Otherwise hold.
- `changed` is a registered output. It is 0 on every edge other than a commit edge that updates `input_data` from SETTLING.
- `data_valid`, once set, stays 1 until the next reset.

## Timing
- Reset values (asserted asynchronously, independent of `clk`):
  - `sync1`=`sync2`=`candidate`=`input_data`=0, `count`=0.
  - `data_valid`=0, `changed`=0, state=INIT.
- Latency: `raw_in` takes a new value that is first sampled by `sync1` at edge E0.
  - `sync2` shows it at E1.
  - SETTLING is entered at E2 with `count`=1.
  - The commit occurs at edge E0+`STABLE_CYCLES`+2, which is E6 for the default.
  - `changed` is high for exactly the one cycle following the commit edge.
- A `raw_in` change that is shorter than the window restarts the count and is never committed. Each new differing `sync2` value restarts the count at 1.
- Back-to-back changes: a new value arriving in the cycle after a commit is handled from STABLE. The minimum spacing between two `changed` pulses is `STABLE_CYCLES`+1 cycles.
- `raw_in` may change on any edge; its metastability is absorbed by `sync1`.
- If `reset` is asserted during SETTLING, the pending value is discarded and all outputs go to their reset values immediately. No `changed` pulse is emitted.
- Reset release is synchronous to `clk` upstream; the block does not re-synchronize it.
- INIT with `raw_in` held at 0 from reset: `data_valid` rises at the (`STABLE_CYCLES`+1)th edge after release, and `input_data` stays 0.

## Test plan
- Reset, then hold `raw_in`=0: all outputs 0 during reset; `data_valid` is 1 after edge 5 (default parameters); `changed` never pulses.
- After the block is valid, `raw_in` goes 0 → 15 before edge E0: `input_data`=15 after E6; `changed`=1 for one cycle only; `data_valid` stays 1.
- With `input_data`=15, set `raw_in`=17 and hold it for 3 cycles, then return to 15: `input_data` stays 15 and `changed` never pulses. The same check applies to a 1-cycle glitch.
- Sequence 15 → 17, held 25 cycles → 0x00FF held 25 cycles: `input_data` is 17 at E0+6 and then 0x00FF 6 edges after its change; exactly two `changed` pulses.
- Assert `reset`=0 in the middle of a clock period while in SETTLING, two cycles after `raw_in` changed to 17: `input_data`, `data_valid` and `changed` go to 0 without waiting for an edge. After release, 17 is committed through the INIT path with no `changed` pulse.
- With `STABLE_CYCLES`=1, step `raw_in` 0 → 5 after the block is valid: `input_data`=5 at E0+3, with one `changed` pulse.
